// File: rtl/reset_sequencer.sv
// reset_sequencer: system reset controller with staged domain release.
// Power-up, a debounced button press or a soft request holds every
// reset domain low for HOLD_CYCLES. The domains are then released in
// ascending index order, STAGE_CYCLES apart.
//
// Optional feature macro: RESET_CAUSE_EN adds a registered cause[1:0]
// output that records what started the most recent reset sequence.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low power-on / FPGA-start reset
//   button     raw asynchronous low-active push buttons
//   soft_req   synchronous high-active single-cycle soft reset request
//   reset_out  low-active domain resets; bit 0 is released first
//   done       high once every reset_out bit is released
//   cause      (RESET_CAUSE_EN only) 00 power-on, 01 button, 10 soft_req
module reset_sequencer #(
    parameter int unsigned NUM_CHANNELS    = 3,
    parameter int unsigned NUM_BUTTONS     = 1,
    parameter int unsigned HOLD_CYCLES     = 5_000_000,
    parameter int unsigned STAGE_CYCLES    = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  button,
    input  logic                    soft_req,
    output logic [NUM_CHANNELS-1:0] reset_out,
    output logic                    done
`ifdef RESET_CAUSE_EN
    ,
    output logic [1:0]              cause
`endif
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [IDX_W-1:0]                     idx_inc;
    logic [NUM_CHANNELS-1:0]              reset_out_q, reset_out_d;
    logic                                 done_q, done_d;
    logic [1:0]                           rst_sync_q, rst_sync_d;
    logic [NUM_BUTTONS-1:0]               btn_s1_q, btn_s1_d;
    logic [NUM_BUTTONS-1:0]               btn_s2_q, btn_s2_d;
    logic [NUM_BUTTONS-1:0][DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                                 press_q, press_d;
    logic                                 trig;
`ifdef RESET_CAUSE_EN
    logic [1:0]                           cause_q, cause_d;
`endif

    // Synchronizers and per-button debouncers. The debounce counter
    // saturates at DEBOUNCE_CYCLES, so a held button fires exactly once
    // and only re-arms after a high sample clears the count.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        btn_s1_d   = button;
        btn_s2_d   = btn_s1_q;
        deb_cnt_d  = deb_cnt_q;
        press_d    = 1'b0;
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            if (btn_s2_q[b]) begin
                deb_cnt_d[b] = '0;
            end else begin
                if (deb_cnt_q[b] != DEB_MAX) begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
                if (deb_cnt_q[b] == DEB_LAST) begin
                    press_d = 1'b1;
                end
            end
        end
    end

    // A soft request and a press in the same cycle are a single trigger.
    assign trig = soft_req | press_q;

    // Sequencer next-state logic. Each channel is released on the edge
    // that selects it, and done rises together with the last channel.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        idx_inc     = idx_q + IDX_W'(1);
        reset_out_d = reset_out_q;
        done_d      = done_q;
`ifdef RESET_CAUSE_EN
        cause_d     = cause_q;
`endif
        if (trig || !rst_sync_q[1]) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            reset_out_d = '0;
            done_d      = 1'b0;
`ifdef RESET_CAUSE_EN
            if (trig) begin
                cause_d = soft_req ? 2'b10 : 2'b01;
            end
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    reset_out_d = '0;
                    done_d      = 1'b0;
                    if (cnt_q == HOLD_LAST) begin
                        state_d     = ST_STAGE;
                        cnt_d       = '0;
                        idx_d       = '0;
                        reset_out_d = NUM_CHANNELS'(1);
                        done_d      = (NUM_CHANNELS == 1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STAGE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == STAGE_LAST) begin
                        cnt_d       = '0;
                        idx_d       = idx_inc;
                        reset_out_d = reset_out_q | (NUM_CHANNELS'(1) << idx_inc);
                        done_d      = (idx_inc == LAST_IDX);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    reset_out_d = '1;
                    done_d      = 1'b1;
                end
                default: begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    reset_out_d = '0;
                    done_d      = 1'b0;
                end
            endcase
        end
    end

    // All state; async reset clears outputs and counters immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            reset_out_q <= '0;
            done_q      <= 1'b0;
            rst_sync_q  <= '0;
            btn_s1_q    <= '1;
            btn_s2_q    <= '1;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
`ifdef RESET_CAUSE_EN
            cause_q     <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            reset_out_q <= reset_out_d;
            done_q      <= done_d;
            rst_sync_q  <= rst_sync_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
`ifdef RESET_CAUSE_EN
            cause_q     <= cause_d;
`endif
        end
    end

    assign reset_out = reset_out_q;
    assign done      = done_q;
`ifdef RESET_CAUSE_EN
    assign cause     = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with HOLD=10, STAGE=4,
// DEBOUNCE=5, three channels and one button. Edge numbers are counted
// from the first rising edge after the stimulus change (that edge is 1).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] button;
    logic       soft_req;
    logic [2:0] reset_out;
    logic       done;
`ifdef RESET_CAUSE_EN
    logic [1:0] cause;
`endif

    int vectors     = 0;
    int miscompares = 0;

    reset_sequencer #(
        .NUM_CHANNELS   (3),
        .NUM_BUTTONS    (1),
        .HOLD_CYCLES    (10),
        .STAGE_CYCLES   (4),
        .DEBOUNCE_CYCLES(5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .soft_req (soft_req),
        .reset_out(reset_out),
        .done     (done)
`ifdef RESET_CAUSE_EN
        ,
        .cause    (cause)
`endif
    );

    always #5 clk = ~clk;

    // Expected outputs after power-up: 001 @12, 011 @16, 111 @20.
    function automatic logic [2:0] powerup_exp(input int e);
        if (e >= 20)      return 3'b111;
        else if (e >= 16) return 3'b011;
        else if (e >= 12) return 3'b001;
        else              return 3'b000;
    endfunction

    // Expected outputs r edges after a trigger edge (r<0: still running).
    function automatic logic [2:0] restart_exp(input int r);
        if (r < 0)        return 3'b111;
        else if (r < 10)  return 3'b000;
        else if (r < 14)  return 3'b001;
        else if (r < 18)  return 3'b011;
        else              return 3'b111;
    endfunction

    task automatic test_reset();
        logic [2:0] exp;
        reset    = 1'b0;
        button   = 1'b1;
        soft_req = 1'b0;
        #1;
        vectors++;
        if ({reset_out, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: reset_out=%b done=%b expected 000/0", reset_out, done);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk);
            #1;
            exp = powerup_exp(e);
            vectors++;
            if ({reset_out, done} !== {exp, 1'(e >= 20)}) begin
                miscompares++;
                $display("FAIL powerup edge %0d: reset_out=%b done=%b expected %b/%b",
                         e, reset_out, done, exp, (e >= 20));
            end
        end
`ifdef RESET_CAUSE_EN
        vectors++;
        if (cause !== 2'b00) begin
            miscompares++;
            $display("FAIL powerup_cause: cause=%b expected 00", cause);
        end
`endif
    endtask

    task automatic test_short_press();
        button = 1'b0;
        repeat (4) @(posedge clk);
        #1 button = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({reset_out, done} !== 4'b1111) begin
                miscompares++;
                $display("FAIL short_press edge %0d: reset_out=%b done=%b expected 111/1",
                         e, reset_out, done);
            end
        end
    endtask

    // Press detected on the 5th synced-low sample (edge 7), restart at edge 8.
    task automatic test_button_press();
        logic [2:0] exp;
        int r;
        button = 1'b0;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
            r   = e - 8;
            exp = restart_exp(r);
            vectors++;
            if ({reset_out, done} !== {exp, 1'(r < 0 || r >= 18)}) begin
                miscompares++;
                $display("FAIL button_press edge %0d: reset_out=%b done=%b expected %b/%b",
                         e, reset_out, done, exp, (r < 0 || r >= 18));
            end
        end
`ifdef RESET_CAUSE_EN
        vectors++;
        if (cause !== 2'b01) begin
            miscompares++;
            $display("FAIL button_cause: cause=%b expected 01", cause);
        end
`endif
        button = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Restart from RUN, then a second soft_req while reset_out=001.
    task automatic test_soft_mid_stage();
        logic [2:0] exp;
        soft_req = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
            soft_req = (e == 11);
            if (e < 11)      exp = 3'b000;
            else if (e < 12) exp = 3'b001;
            else             exp = restart_exp(e - 12);
            vectors++;
            if ({reset_out, done} !== {exp, 1'(e >= 30)}) begin
                miscompares++;
                $display("FAIL soft_mid_stage edge %0d: reset_out=%b done=%b expected %b/%b",
                         e, reset_out, done, exp, (e >= 30));
            end
        end
`ifdef RESET_CAUSE_EN
        vectors++;
        if (cause !== 2'b10) begin
            miscompares++;
            $display("FAIL soft_cause: cause=%b expected 10", cause);
        end
`endif
    endtask

    // soft_req lands on the same edge as the debounced press (edge 8).
    task automatic test_simultaneous();
        logic [2:0] exp;
        int r;
        button = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            soft_req = (e == 7);
            r   = e - 8;
            exp = restart_exp(r);
            vectors++;
            if ({reset_out, done} !== {exp, 1'(r < 0 || r >= 18)}) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: reset_out=%b done=%b expected %b/%b",
                         e, reset_out, done, exp, (r < 0 || r >= 18));
            end
        end
`ifdef RESET_CAUSE_EN
        vectors++;
        if (cause !== 2'b10) begin
            miscompares++;
            $display("FAIL simultaneous_cause: cause=%b expected 10", cause);
        end
`endif
        button   = 1'b1;
        soft_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        logic [2:0] exp;
        soft_req = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1 soft_req = 1'b0;
        end
        vectors++;
        if ({reset_out, done} !== 4'b0010) begin
            miscompares++;
            $display("FAIL async_pre_stage: reset_out=%b done=%b expected 001/0", reset_out, done);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({reset_out, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_no_edge: reset_out=%b done=%b expected 000/0", reset_out, done);
        end
`ifdef RESET_CAUSE_EN
        vectors++;
        if (cause !== 2'b00) begin
            miscompares++;
            $display("FAIL async_cause: cause=%b expected 00", cause);
        end
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk);
            #1;
            exp = powerup_exp(e);
            vectors++;
            if ({reset_out, done} !== {exp, 1'(e >= 20)}) begin
                miscompares++;
                $display("FAIL async_repowerup edge %0d: reset_out=%b done=%b expected %b/%b",
                         e, reset_out, done, exp, (e >= 20));
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_button_press();
        test_soft_mid_stage();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
